baud_tick_gen: RTL

- Programmable fractional-N baud tick generator; successor to the fixed 50%-duty toggling baud divider.
- Emits single-cycle clock-enable pulses in the clk domain: rxTick at BAUD×RX_OVERSAMPLE_RATE and txTick at BAUD, phase-locked to rxTick.
- Divisor is reloadable at runtime, with glitch-free apply at a tick boundary.
- Per-receiver resync aligns the oversample phase to a detected start bit.
- Feeds UART rx/tx cores, which use the ticks as enables, not as clocks.

---
 rtl/baud_tick_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional-N rx/tx clock-enable generator for UART cores.
// Define BAUD_TICK_FRAC_EN to build in the fractional phase accumulator.
module baud_tick_gen #(
  parameter int unsigned CLOCK_RATE         = 100000000,
  parameter int unsigned BAUD_RATE          = 9600,
  parameter int unsigned RX_OVERSAMPLE_RATE = 16,
  parameter int unsigned DIV_WIDTH          = 16,
  parameter int unsigned FRAC_BITS          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 cfg_load,
  input  logic [DIV_WIDTH-1:0] cfg_int,
  input  logic [FRAC_BITS-1:0] cfg_frac,
  input  logic                 rx_resync,
  output logic                 cfg_pending,
  output logic                 rxTick,
  output logic                 txTick
);

  localparam int OSW = $clog2(RX_OVERSAMPLE_RATE);
  localparam logic [OSW-1:0] OS_MAX =
    OSW'(RX_OVERSAMPLE_RATE - 1);
  localparam logic [63:0] RATE =
    64'(BAUD_RATE) * 64'(RX_OVERSAMPLE_RATE);

`ifdef BAUD_TICK_FRAC_EN
  localparam logic [63:0] DEF_D =
    ((64'(CLOCK_RATE) << FRAC_BITS) + RATE / 2) / RATE;
  localparam logic [DIV_WIDTH-1:0] DEF_INT =
    DIV_WIDTH'(DEF_D >> FRAC_BITS);
  localparam logic [FRAC_BITS-1:0] DEF_FRAC =
    FRAC_BITS'(DEF_D);
`else
  localparam logic [63:0] DEF_D =
    (64'(CLOCK_RATE) + RATE / 2) / RATE;
  localparam logic [DIV_WIDTH-1:0] DEF_INT =
    DIV_WIDTH'(DEF_D);
`endif

  logic [DIV_WIDTH-1:0] div_int_q, div_int_d;
  logic [DIV_WIDTH-1:0] shd_int_q, shd_int_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic [DIV_WIDTH-1:0] pm1;
  logic [OSW-1:0]       os_cnt_q, os_cnt_d;
  logic                 pend_q, pend_d;
  logic                 rx_q, rx_d;
  logic                 tx_q, tx_d;
  logic                 wrap;
  logic                 apply;

`ifdef BAUD_TICK_FRAC_EN
  logic [FRAC_BITS-1:0] div_frac_q, div_frac_d;
  logic [FRAC_BITS-1:0] shd_frac_q, shd_frac_d;
  logic [FRAC_BITS-1:0] acc_q, acc_d;
  logic                 carry_q, carry_d;
  logic [FRAC_BITS:0]   sum;
`else
  logic unused_frac;
  assign unused_frac = ^cfg_frac;
`endif

  always_comb begin
    pm1 = (div_int_q == '0) ? '0
        : div_int_q - DIV_WIDTH'(1);
`ifdef BAUD_TICK_FRAC_EN
    pm1 = pm1 + DIV_WIDTH'(carry_q);
    sum = {1'b0, acc_q} + {1'b0, div_frac_q};
    div_frac_d = div_frac_q;
    shd_frac_d = shd_frac_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
`endif
    wrap      = enable && (rx_cnt_q >= pm1);
    apply     = wrap && pend_q;
    div_int_d = div_int_q;
    shd_int_d = shd_int_q;
    pend_d    = pend_q;
    rx_cnt_d  = rx_cnt_q;
    os_cnt_d  = os_cnt_q;
    rx_d      = 1'b0;
    tx_d      = 1'b0;

    if (cfg_load) begin
      shd_int_d = cfg_int;
`ifdef BAUD_TICK_FRAC_EN
      shd_frac_d = cfg_frac;
`endif
    end

    if (!enable) begin
      rx_cnt_d = '0;
      os_cnt_d = '0;
`ifdef BAUD_TICK_FRAC_EN
      acc_d   = '0;
      carry_d = 1'b0;
`endif
      // Idle: a new divisor needs no tick boundary to land safely.
      if (cfg_load) begin
        div_int_d = cfg_int;
`ifdef BAUD_TICK_FRAC_EN
        div_frac_d = cfg_frac;
`endif
        pend_d = 1'b0;
      end
    end else begin
      if (apply) begin
        div_int_d = shd_int_q;
`ifdef BAUD_TICK_FRAC_EN
        div_frac_d = shd_frac_q;
`endif
        pend_d = 1'b0;
      end
      if (cfg_load) pend_d = 1'b1;

      if (rx_resync) begin
        rx_cnt_d = '0;
        os_cnt_d = '0;
`ifdef BAUD_TICK_FRAC_EN
        carry_d = 1'b0;
`endif
      end else if (wrap) begin
        rx_cnt_d = '0;
        rx_d     = 1'b1;
        tx_d     = (os_cnt_q == OS_MAX);
        os_cnt_d = tx_d ? '0 : os_cnt_q + OSW'(1);
`ifdef BAUD_TICK_FRAC_EN
        {carry_d, acc_d} = sum;
`endif
      end else begin
        rx_cnt_d = rx_cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_int_q <= DEF_INT;
      shd_int_q <= DEF_INT;
      rx_cnt_q  <= '0;
      os_cnt_q  <= '0;
      pend_q    <= 1'b0;
      rx_q      <= 1'b0;
      tx_q      <= 1'b0;
`ifdef BAUD_TICK_FRAC_EN
      div_frac_q <= DEF_FRAC;
      shd_frac_q <= DEF_FRAC;
      acc_q      <= '0;
      carry_q    <= 1'b0;
`endif
    end else begin
      div_int_q <= div_int_d;
      shd_int_q <= shd_int_d;
      rx_cnt_q  <= rx_cnt_d;
      os_cnt_q  <= os_cnt_d;
      pend_q    <= pend_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
`ifdef BAUD_TICK_FRAC_EN
      div_frac_q <= div_frac_d;
      shd_frac_q <= shd_frac_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
`endif
    end
  end

  assign cfg_pending = pend_q;
  assign rxTick      = rx_q;
  assign txTick      = tx_q;

endmodule
